// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, byte-lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with an error instead of aligning down.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;

    logic              req_ready_d, mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [3:0]        mem_be_d;
    logic [31:0]       mem_wdata_d;
    logic              rsp_valid_d, rsp_err_d;
    logic [31:0]       rsp_rdata_d;

    logic              acc_err_c;
    logic [1:0]        off_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [7:0]        byte_sel_c;
    logic [15:0]       half_sel_c;
    logic [31:0]       rdata_ext_c;

    // Decode the incoming request: legality, effective byte offset, lane enables, replicated store data
    always_comb begin
        if (req_we_i)
            acc_err_c = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
        else
            acc_err_c = (req_funct3_i[1:0] == 2'b11) | (req_funct3_i == 3'b110);
        off_c   = req_addr_i[1:0];
        be_c    = 4'b1111;
        wdata_c = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00: begin
                be_c    = 4'(4'b0001 << req_addr_i[1:0]);
                wdata_c = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                off_c   = {req_addr_i[1], 1'b0};
                be_c    = 4'(4'b0011 << {req_addr_i[1], 1'b0});
                wdata_c = {2{req_wdata_i[15:0]}};
            end
            default: off_c = 2'b00;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        acc_err_c = acc_err_c
                  | ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0])
                  | ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));
`endif
    end

    // Select and extend the addressed lane of the returned word
    always_comb begin
        byte_sel_c = mem_rdata_i[{off_q, 3'b000} +: 8];
        half_sel_c = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q[1:0])
            2'b00:   rdata_ext_c = {{24{~funct3_q[2] & byte_sel_c[7]}}, byte_sel_c};
            2'b01:   rdata_ext_c = {{16{~funct3_q[2] & half_sel_c[15]}}, half_sel_c};
            default: rdata_ext_c = mem_rdata_i;
        endcase
    end

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o;
        mem_be_d    = mem_be_o;
        mem_wdata_d = mem_wdata_o;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    off_d    = off_c;
                    if (acc_err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = req_we_i ? wdata_c : 32'h0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d     = WAIT;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = 4'h0;
                    mem_wdata_d = 32'h0;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : rdata_ext_c;
                end
            end
            RESP: begin
                state_d  = IDLE;
                we_d     = 1'b0;
                funct3_d = 3'b000;
                off_d    = 2'b00;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            req_ready_o <= 1'b1;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'h0;
            mem_wdata_o <= 32'h0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            req_ready_o <= req_ready_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_be_o    <= mem_be_d;
            mem_wdata_o <= mem_wdata_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_err_o   <= rsp_err_d;
            rsp_rdata_o <= rsp_rdata_d;
        end
    end

endmodule
